// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyph constants and tracker state type
package seg7_pkg;

   // Active-low cathode patterns, bit6=a .. bit0=g
   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0001100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      CAPTURED
   } trk_state_e;

endpackage

// File: rtl/seg7_inv_decode.sv
// rtl/seg7_inv_decode.sv - maps an active-low 7-segment pattern back to its hex nibble
module seg7_inv_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       match
);

   always_comb begin
      nibble = 4'h0;
      match  = 1'b1;
      case (pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: match  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_reader.sv
// rtl/seg_scan_reader.sv - snoops a multiplexed 4-digit 7-seg bus and rebuilds 16-bit frames
module seg_scan_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic [3:0]  digit_err,
   output logic        stale
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

   logic [6:0]  seg_m_q, seg_s_q;
   logic [3:0]  an_m_q, an_s_q;
   trk_state_e  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [6:0]  pat_q, pat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0] shadow_q, shadow_d;
   logic [3:0]  seen_q, seen_d;
   logic [3:0]  err_q, err_d;
   logic [15:0] value_q, value_d;
   logic        fv_q, fv_d;
   logic [TW-1:0] to_q, to_d;

   logic        an_valid;
   logic [1:0]  an_idx;
   logic        same;
   logic        capture;
   logic        frame;
   logic [3:0]  cap_mask;
   logic [3:0]  dec_nibble;
   logic        dec_match;

   seg7_inv_decode u_dec (
      .pattern (pat_q),
      .nibble  (dec_nibble),
      .match   (dec_match)
   );

   // Only a single low anode identifies a digit; anything else is treated as blanking
   always_comb begin
      an_valid = 1'b1;
      an_idx   = 2'd0;
      case (an_s_q)
         4'b1110: an_idx = 2'd0;
         4'b1101: an_idx = 2'd1;
         4'b1011: an_idx = 2'd2;
         4'b0111: an_idx = 2'd3;
         default: an_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      same    = (an_idx == idx_q) && (seg_s_q == pat_q);
      case (state_q)
         IDLE: begin
            if (an_valid) begin
               state_d = TRACK;
               idx_d   = an_idx;
               pat_d   = seg_s_q;
               cnt_d   = CW'(1);
            end
         end
         TRACK: begin
            if (!an_valid) begin
               state_d = IDLE;
            end else if (same) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = CAPTURED;
                  capture = 1'b1;
               end
            end else begin
               idx_d = an_idx;
               pat_d = seg_s_q;
               cnt_d = CW'(1);
            end
         end
         CAPTURED: begin
            // Held dwell: wait for the strobe to move on before tracking again
            if (!an_valid) begin
               state_d = IDLE;
            end else if (!same) begin
               state_d = TRACK;
               idx_d   = an_idx;
               pat_d   = seg_s_q;
               cnt_d   = CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cap_mask = capture ? (4'b0001 << idx_q) : 4'b0000;
      frame    = (seen_q == 4'b1111);
      shadow_d = shadow_q;
      if (capture) begin
         shadow_d[idx_q*4 +: 4] = dec_match ? dec_nibble : 4'h0;
      end
      // Errors captured in the frame cycle belong to the next frame, so they survive the clear
      seen_d  = (frame ? 4'b0000 : seen_q) | cap_mask;
      err_d   = (frame ? 4'b0000 : err_q) | (dec_match ? 4'b0000 : cap_mask);
      value_d = frame ? shadow_q : value_q;
      fv_d    = frame;
      if (capture) begin
         to_d = '0;
      end else if (to_q == TO_MAX) begin
         to_d = to_q;
      end else begin
         to_d = to_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_m_q  <= 7'h7F;
         seg_s_q  <= 7'h7F;
         an_m_q   <= 4'hF;
         an_s_q   <= 4'hF;
         state_q  <= IDLE;
         idx_q    <= 2'd0;
         pat_q    <= 7'h7F;
         cnt_q    <= '0;
         shadow_q <= 16'h0000;
         seen_q   <= 4'b0000;
         err_q    <= 4'b0000;
         value_q  <= 16'h0000;
         fv_q     <= 1'b0;
         to_q     <= '0;
      end else begin
         seg_m_q  <= seg_in;
         seg_s_q  <= seg_m_q;
         an_m_q   <= an_in;
         an_s_q   <= an_m_q;
         state_q  <= state_d;
         idx_q    <= idx_d;
         pat_q    <= pat_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         seen_q   <= seen_d;
         err_q    <= err_d;
         value_q  <= value_d;
         fv_q     <= fv_d;
         to_q     <= to_d;
      end
   end

   assign value       = value_q;
   assign frame_valid = fv_q;
   assign digit_err   = err_q;
   assign stale       = (to_q == TO_MAX);

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb/tb_seg_scan_reader.sv - directed self-checking bench for seg_scan_reader
module tb_seg_scan_reader;
   import seg7_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic [15:0] value;
   logic        frame_valid;
   logic [3:0]  digit_err;
   logic        stale;

   int          n_vec = 0;
   int          n_bad = 0;
   int          fv_cnt = 0;
   int          stale_falls = 0;
   int          s0;
   logic        prev_stale = 1'b0;
   logic [15:0] last_val = 16'h0000;

   seg_scan_reader #(
      .STABLE_CYCLES  (16),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .an_in       (an_in),
      .value       (value),
      .frame_valid (frame_valid),
      .digit_err   (digit_err),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_valid) begin
            fv_cnt   = fv_cnt + 1;
            last_val = value;
         end
         if (prev_stale && !stale) stale_falls = stale_falls + 1;
         prev_stale = stale;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_in  = an;
      seg_in = seg;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_frame(input int max_cycles);
      int n = 0;
      while (!frame_valid && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check_eq("frame_seen", 32'(frame_valid), 32'd1);
   endtask

   initial begin
      an_in  = 4'b1111;
      seg_in = 7'h7F;
      repeat (3) begin
         @(negedge clk);
         an_in  = 4'($urandom);
         seg_in = 7'($urandom);
      end
      @(negedge clk);
      check_eq("rst_value", 32'(value), 32'h0000);
      check_eq("rst_fv", 32'(frame_valid), 32'd0);
      check_eq("rst_err", 32'(digit_err), 32'd0);
      check_eq("rst_stale", 32'(stale), 32'd0);
      an_in  = 4'b1111;
      seg_in = 7'h7F;
      rst_n  = 1'b1;
      drive(4'b1111, 7'h7F, 5);

      // clean scan
      drive(4'b1110, SEG_4, 1000);
      drive(4'b1101, SEG_3, 1000);
      drive(4'b1011, SEG_2, 1000);
      drive(4'b0111, SEG_1, 1000);
      check_eq("clean_fv_cnt", 32'(fv_cnt), 32'd1);
      check_eq("clean_value", 32'(last_val), 32'h1234);
      check_eq("clean_err", 32'(digit_err), 32'd0);

      // glitch rejection with blank gaps
      drive(4'b1111, 7'h7F, 5);
      drive(4'b1110, SEG_7, 10);
      drive(4'b1110, SEG_9, 20);
      drive(4'b1111, 7'h7F, 5);
      drive(4'b1101, SEG_5, 30);
      drive(4'b1111, 7'h7F, 5);
      drive(4'b1011, SEG_6, 30);
      drive(4'b1111, 7'h7F, 5);
      check_eq("glitch_no_early", 32'(fv_cnt), 32'd1);
      drive(4'b0111, SEG_8, 30);
      drive(4'b1111, 7'h7F, 5);
      check_eq("glitch_fv_cnt", 32'(fv_cnt), 32'd2);
      check_eq("glitch_value", 32'(last_val), 32'h8659);

      // unrecognised pattern on digit2
      drive(4'b1110, SEG_A, 30);
      drive(4'b1101, SEG_B, 30);
      drive(4'b1011, 7'b1111111, 30);
      check_eq("inv_err", 32'(digit_err), 32'h4);
      drive(4'b0111, SEG_C, 30);
      check_eq("inv_fv_cnt", 32'(fv_cnt), 32'd3);
      check_eq("inv_value", 32'(last_val), 32'hC0BA);
      drive(4'b1110, SEG_D, 30);
      drive(4'b1101, SEG_E, 30);
      drive(4'b1011, SEG_F, 30);
      drive(4'b0111, SEG_0, 30);
      check_eq("reclean_value", 32'(last_val), 32'h0FED);
      check_eq("reclean_err", 32'(digit_err), 32'd0);

      // multi-anode strobe must not count as a digit
      drive(4'b1110, SEG_1, 30);
      drive(4'b1101, SEG_2, 30);
      drive(4'b1011, SEG_3, 30);
      drive(4'b1100, SEG_4, 100);
      check_eq("multi_no_frame", 32'(fv_cnt), 32'd4);
      drive(4'b0111, SEG_4, 30);
      check_eq("multi_fv_cnt", 32'(fv_cnt), 32'd5);
      check_eq("multi_value", 32'(last_val), 32'h4321);

      // long single dwell captures once
      drive(4'b1111, 7'h7F, 100);
      check_eq("blank_stale", 32'(stale), 32'd1);
      s0 = stale_falls;
      drive(4'b1110, SEG_6, 5000);
      check_eq("dwell_captures", 32'(stale_falls - s0), 32'd1);
      check_eq("dwell_stale", 32'(stale), 32'd1);

      // stale drops one cycle after the capture
      an_in  = 4'b1101;
      seg_in = SEG_1;
      repeat (17) @(negedge clk);
      check_eq("pre_cap_stale", 32'(stale), 32'd1);
      check_eq("stale_value_held", 32'(value), 32'h4321);
      @(negedge clk);
      check_eq("post_cap_stale", 32'(stale), 32'd0);
      drive(4'b1101, SEG_1, 20);

      // timeout measured from the final capture
      drive(4'b1011, SEG_2, 30);
      an_in  = 4'b0111;
      seg_in = SEG_3;
      wait_frame(100);
      an_in  = 4'b1111;
      seg_in = 7'h7F;
      repeat (62) @(negedge clk);
      check_eq("to_before", 32'(stale), 32'd0);
      @(negedge clk);
      check_eq("to_reached", 32'(stale), 32'd1);
      check_eq("to_value", 32'(value), 32'h3216);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
